// File: rtl/ssd_pkg.sv
// Shared PmodSSD definitions: glyph table (gfedcba), blank pattern and Pmod pin positions.
package ssd_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t GLYPH_0   = 7'h3F;
   localparam seg_t GLYPH_1   = 7'h06;
   localparam seg_t GLYPH_2   = 7'h5B;
   localparam seg_t GLYPH_3   = 7'h4F;
   localparam seg_t GLYPH_4   = 7'h66;
   localparam seg_t GLYPH_5   = 7'h6D;
   localparam seg_t GLYPH_6   = 7'h7D;
   localparam seg_t GLYPH_7   = 7'h07;
   localparam seg_t GLYPH_8   = 7'h7F;
   localparam seg_t GLYPH_9   = 7'h6F;
   localparam seg_t GLYPH_A   = 7'h77;
   localparam seg_t GLYPH_B   = 7'h7C;
   localparam seg_t GLYPH_C   = 7'h39;
   localparam seg_t GLYPH_D   = 7'h5E;
   localparam seg_t GLYPH_E   = 7'h79;
   localparam seg_t GLYPH_F   = 7'h71;
   localparam seg_t SEG_BLANK = 7'h00;

   // PmodPort1[7:4] = seg[3:0], PmodPort2[6:4] = seg[6:4], PmodPort2[7] = sel
   localparam int P1_SEG_LO  = 4;
   localparam int P2_SEG_LO  = 4;
   localparam int P2_SEL_BIT = 7;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational seven-segment to hex decoder; only the canonical glyphs are legal.
module ssd_seg_decode
   import ssd_pkg::*;
(
   input  seg_t       seg,
   output logic       legal,
   output logic       blank,
   output logic [3:0] nibble
);

   always_comb begin
      legal  = 1'b1;
      blank  = (seg == SEG_BLANK);
      nibble = 4'h0;
      case (seg)
         GLYPH_0: nibble = 4'h0;
         GLYPH_1: nibble = 4'h1;
         GLYPH_2: nibble = 4'h2;
         GLYPH_3: nibble = 4'h3;
         GLYPH_4: nibble = 4'h4;
         GLYPH_5: nibble = 4'h5;
         GLYPH_6: nibble = 4'h6;
         GLYPH_7: nibble = 4'h7;
         GLYPH_8: nibble = 4'h8;
         GLYPH_9: nibble = 4'h9;
         GLYPH_A: nibble = 4'hA;
         GLYPH_B: nibble = 4'hB;
         GLYPH_C: nibble = 4'hC;
         GLYPH_D: nibble = 4'hD;
         GLYPH_E: nibble = 4'hE;
         GLYPH_F: nibble = 4'hF;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/ssd_pin_decoder.sv
// Rebuilds a multiplexed two-digit PmodSSD display from its pins into per-position nibbles.
// SSD_PIN_DECODER_SYNC_EN adds a 2-flop synchronizer in front of the sample register.
module ssd_pin_decoder
   import ssd_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] PmodPort1,
   input  logic [7:0] PmodPort2,
   output logic [3:0] digit_lsb,
   output logic [3:0] digit_msb,
   output logic [1:0] valid,
   output logic       upd,
   output logic       err,
   output logic [7:0] err_cnt,
   output logic       stall
);

   localparam logic [7:0]  STABLE = 8'(STABLE_CYCLES);
   localparam logic [31:0] TMO    = 32'(TIMEOUT_CYCLES);
   localparam seg_t        INV    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   logic [7:0] pin_word;
   logic       unused_pins;
   assign pin_word    = {PmodPort2[P2_SEL_BIT], PmodPort2[P2_SEG_LO +: 3], PmodPort1[P1_SEG_LO +: 4]};
   assign unused_pins = ^{PmodPort1[3:0], PmodPort2[3:0]};

   logic [7:0] samp;
   logic       samp_vld;

`ifdef SSD_PIN_DECODER_SYNC_EN
   logic [7:0] sync1, sync2;
   logic [2:0] vld_pipe;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= 8'h00;
         sync2    <= 8'h00;
         samp     <= 8'h00;
         vld_pipe <= 3'b000;
      end else begin
         sync1    <= pin_word;
         sync2    <= sync1;
         samp     <= sync2;
         vld_pipe <= {vld_pipe[1:0], 1'b1};
      end
   end
   assign samp_vld = vld_pipe[2];
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         samp     <= 8'h00;
         samp_vld <= 1'b0;
      end else begin
         samp     <= pin_word;
         samp_vld <= 1'b1;
      end
   end
`endif

   // samp_vld keeps the cleared register contents from being counted as a sample
   logic [7:0] run_cnt, last_word, cnt_next;
   logic       new_run, commit;
   assign new_run  = (run_cnt == 8'd0) || (samp != last_word);
   assign cnt_next = new_run ? 8'd1 : ((run_cnt == STABLE) ? STABLE : run_cnt + 8'd1);
   assign commit   = samp_vld && (cnt_next == STABLE) && (new_run || (run_cnt != STABLE));

   seg_t       seg;
   logic       pos, legal, blank;
   logic [3:0] nibble;
   assign seg = samp[6:0] ^ INV;
   assign pos = samp[7];

   ssd_seg_decode u_dec (
      .seg    (seg),
      .legal  (legal),
      .blank  (blank),
      .nibble (nibble)
   );

   logic [31:0] tmr;
   logic        prev_pos, pos_chg, tmo_hit;
   assign pos_chg = commit && (pos != prev_pos);
   assign tmo_hit = (tmr == 32'd1) && !pos_chg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_cnt   <= 8'd0;
         last_word <= 8'h00;
         prev_pos  <= 1'b0;
         tmr       <= TMO;
         digit_lsb <= 4'h0;
         digit_msb <= 4'h0;
         valid     <= 2'b00;
         upd       <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= 8'd0;
         stall     <= 1'b0;
      end else begin
         upd <= 1'b0;
         err <= 1'b0;
         if (samp_vld) begin
            last_word <= samp;
            run_cnt   <= cnt_next;
         end
         if (commit) begin
            upd      <= 1'b1;
            prev_pos <= pos;
            valid[pos] <= legal;
            if (legal) begin
               if (pos) digit_msb <= nibble;
               else     digit_lsb <= nibble;
            end else if (!blank) begin
               err <= 1'b1;
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
         end
         if (pos_chg) begin
            tmr   <= TMO;
            stall <= 1'b0;
         end else if (tmr != 32'd0) begin
            tmr <= tmr - 32'd1;
         end
         if (tmo_hit) begin
            stall           <= 1'b1;
            valid[~prev_pos] <= 1'b0;
         end
      end
   end

endmodule
